mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_pkg.sv | 36 +++
 rtl/mem_bus_responder_if.sv | 35 +++
 rtl/mem_bus_wait_counter.sv | 28 ++
 rtl/mem_bus_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types, widths and request decoding for the CPU memory-bus responder.
package mem_bus_pkg;

  localparam int unsigned WaitW = 3;
  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 8;
  localparam int unsigned RfshW = 7;
  localparam int unsigned OpW   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRwait,
    StRdata,
    StWwait,
    StHold,
    StRfsh
  } state_e;

  typedef enum logic [2:0] {
    ReqNone,
    ReqRfsh,
    ReqRead,
    ReqWrite,
    ReqErr
  } req_e;

  // Classify the strobes seen alongside MREQ; illegal combinations win over everything.
  function automatic req_e decode_req(logic rd, logic wr, logic rfsh);
    if ((rd && wr) || (rfsh && (rd || wr))) return ReqErr;
    if (rfsh) return ReqRfsh;
    if (rd) return ReqRead;
    if (wr) return ReqWrite;
    return ReqNone;
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU-side strobes plus memory-array port of the bus responder.
interface mem_bus_responder_if;
  import mem_bus_pkg::*;

  logic [AddrW-1:0] Ad;
  logic             Flag_M1;
  logic             Flag_MREQ;
  logic             Flag_RD;
  logic             Flag_WR;
  logic             Flag_RFSH;
  logic [DataW-1:0] Dout;
  logic [DataW-1:0] Din;
  logic             TWAIT;
  logic [AddrW-1:0] MEM_Addr;
  logic [DataW-1:0] MEM_Wdata;
  logic             MEM_Rd;
  logic             MEM_We;
  logic [DataW-1:0] MEM_Rdata;
  logic [RfshW-1:0] RFSH_Count;
  logic [OpW-1:0]   OP_Count;
  logic             ERR;

  // Responder side.
  modport slave (
    input  Ad, Flag_M1, Flag_MREQ, Flag_RD, Flag_WR, Flag_RFSH, Dout, MEM_Rdata,
    output Din, TWAIT, MEM_Addr, MEM_Wdata, MEM_Rd, MEM_We, RFSH_Count, OP_Count, ERR
  );

  // CPU and memory-array side.
  modport master (
    output Ad, Flag_M1, Flag_MREQ, Flag_RD, Flag_WR, Flag_RFSH, Dout, MEM_Rdata,
    input  Din, TWAIT, MEM_Addr, MEM_Wdata, MEM_Rd, MEM_We, RFSH_Count, OP_Count, ERR
  );

endinterface

// File: rtl/mem_bus_wait_counter.sv
// Wait-state down-counter: load a count, step it down, report when it has reached zero.
module mem_bus_wait_counter
  import mem_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WaitW-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WaitW-1:0] cnt_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-bus responder: turns CPU MREQ/RD/WR/RFSH strobes into single-cycle array
// accesses with configurable wait states, and keeps refresh/fetch counters.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned WAIT_M1  = 1,
  parameter int unsigned WAIT_MEM = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  mem_bus_responder_if.slave  bus
);

  localparam logic [WaitW-1:0] WaitM1Val  = WaitW'(WAIT_M1);
  localparam logic [WaitW-1:0] WaitMemVal = WaitW'(WAIT_MEM);

  state_e           state_q, state_d;
  logic [DataW-1:0] din_q, din_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic             twait_q, twait_d;
  logic [RfshW-1:0] rfsh_q, rfsh_d;
  logic [OpW-1:0]   op_q, op_d;
  logic             err_q, err_d;
  logic             m1_q, m1_d;

  logic             cnt_load;
  logic [WaitW-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             mem_rd;
  logic             mem_we;

  mem_bus_wait_counter u_wait_counter (
    .clk      (CLK),
    .rst      (RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      din_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      twait_q <= 1'b1;
      rfsh_q  <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      m1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      twait_q <= twait_d;
      rfsh_q  <= rfsh_d;
      op_q    <= op_d;
      err_q   <= err_d;
      m1_q    <= m1_d;
    end
  end

  // Next state, datapath updates and the array strobes.
  // Strobes are combinational and gated by MREQ so an abort in the final wait cycle
  // never reaches the array; the array answers a read on the following cycle.
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    twait_d  = twait_q;
    rfsh_d   = rfsh_q;
    op_d     = op_q;
    err_d    = err_q;
    m1_d     = m1_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    mem_rd   = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.Flag_MREQ) begin
          case (decode_req(bus.Flag_RD, bus.Flag_WR, bus.Flag_RFSH))
            ReqErr: begin
              err_d   = 1'b1;
              state_d = StHold;
            end
            ReqRfsh: begin
              rfsh_d  = rfsh_q + 1'b1;
              state_d = StRfsh;
            end
            ReqRead: begin
              addr_d   = bus.Ad;
              m1_d     = bus.Flag_M1;
              cnt_load = 1'b1;
              cnt_val  = bus.Flag_M1 ? WaitM1Val : WaitMemVal;
              twait_d  = 1'b0;
              state_d  = StRwait;
            end
            ReqWrite: begin
              addr_d   = bus.Ad;
              wdata_d  = bus.Dout;
              cnt_load = 1'b1;
              cnt_val  = WaitMemVal;
              twait_d  = 1'b0;
              state_d  = StWwait;
            end
            default: ;
          endcase
        end
      end
      StRwait: begin
        if (!bus.Flag_MREQ) begin
          twait_d = 1'b1;
          state_d = StIdle;
        end else if (cnt_zero) begin
          mem_rd  = 1'b1;
          state_d = StRdata;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StRdata: begin
        din_d   = bus.MEM_Rdata;
        twait_d = 1'b1;
        if (m1_q) op_d = op_q + 1'b1;
        state_d = StHold;
      end
      StWwait: begin
        if (!bus.Flag_MREQ) begin
          twait_d = 1'b1;
          state_d = StIdle;
        end else if (cnt_zero) begin
          mem_we  = 1'b1;
          twait_d = 1'b1;
          state_d = StHold;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StHold, StRfsh: begin
        if (!bus.Flag_MREQ) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.Din        = din_q;
  assign bus.TWAIT      = twait_q;
  assign bus.MEM_Addr   = addr_q;
  assign bus.MEM_Wdata  = wdata_q;
  assign bus.MEM_Rd     = mem_rd;
  assign bus.MEM_We     = mem_we;
  assign bus.RFSH_Count = rfsh_q;
  assign bus.OP_Count   = op_q;
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances with different wait settings driven by one
// CPU model, each with its own memory array, checked against a transaction-level model.
module tb_mem_bus_responder;

  localparam int unsigned WaitM1A  = 1;
  localparam int unsigned WaitMemA = 0;
  localparam int unsigned WaitM1B  = 2;
  localparam int unsigned WaitMemB = 3;

  typedef enum int {KNone, KRead, KWrite, KRfsh, KErr} kind_e;

  typedef struct {
    kind_e       kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        m1;
    logic [7:0]  exp_din;
    int          exp_lat_a;
    int          exp_lat_b;
    logic [15:0] exp_op;
    logic [6:0]  exp_rfsh;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cpu_ad = '0;
  logic        cpu_m1 = 1'b0, cpu_mreq = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_rfsh = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  rdata_a = '0, rdata_b = '0;

  logic [7:0] mem_a   [65536];
  logic [7:0] mem_b   [65536];
  logic [7:0] ref_mem [65536];

  int rd_a = 0, rd_b = 0, we_a = 0, we_b = 0, excl = 0;
  int n_tests = 0, n_fail = 0;

  // Reference model state.
  logic [7:0]  exp_din = '0;
  logic [15:0] exp_op = '0;
  logic [6:0]  exp_rfsh = '0;
  logic        exp_err = 1'b0;
  int          exp_rd = 0, exp_we = 0;

  mem_bus_responder_if bus_a ();
  mem_bus_responder_if bus_b ();

  assign bus_a.Ad = cpu_ad;         assign bus_b.Ad = cpu_ad;
  assign bus_a.Flag_M1 = cpu_m1;    assign bus_b.Flag_M1 = cpu_m1;
  assign bus_a.Flag_MREQ = cpu_mreq; assign bus_b.Flag_MREQ = cpu_mreq;
  assign bus_a.Flag_RD = cpu_rd;    assign bus_b.Flag_RD = cpu_rd;
  assign bus_a.Flag_WR = cpu_wr;    assign bus_b.Flag_WR = cpu_wr;
  assign bus_a.Flag_RFSH = cpu_rfsh; assign bus_b.Flag_RFSH = cpu_rfsh;
  assign bus_a.Dout = cpu_dout;     assign bus_b.Dout = cpu_dout;
  assign bus_a.MEM_Rdata = rdata_a; assign bus_b.MEM_Rdata = rdata_b;

  mem_bus_responder #(.WAIT_M1(WaitM1A), .WAIT_MEM(WaitMemA)) dut_a (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_a.slave)
  );

  mem_bus_responder #(.WAIT_M1(WaitM1B), .WAIT_MEM(WaitMemB)) dut_b (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_b.slave)
  );

  // Synchronous memory arrays: write on MEM_We, read data valid the cycle after MEM_Rd.
  always @(posedge clk) begin
    if (bus_a.MEM_We) begin mem_a[bus_a.MEM_Addr] <= bus_a.MEM_Wdata; we_a <= we_a + 1; end
    if (bus_a.MEM_Rd) begin rdata_a <= mem_a[bus_a.MEM_Addr]; rd_a <= rd_a + 1; end
    if (bus_b.MEM_We) begin mem_b[bus_b.MEM_Addr] <= bus_b.MEM_Wdata; we_b <= we_b + 1; end
    if (bus_b.MEM_Rd) begin rdata_b <= mem_b[bus_b.MEM_Addr]; rd_b <= rd_b + 1; end
    if ((bus_a.MEM_Rd && bus_a.MEM_We) || (bus_b.MEM_Rd && bus_b.MEM_We)) excl <= excl + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] init_byte(int unsigned i);
    logic [15:0] a;
    a = 16'(i);
    return a[7:0] ^ a[15:8] ^ 8'h3E;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [7:0] din, logic [15:0] op, logic [6:0] rfsh,
                            logic err);
    check({tag, ".din"}, 32'(din), 32'(exp_din));
    check({tag, ".op_count"}, 32'(op), 32'(exp_op));
    check({tag, ".rfsh_count"}, 32'(rfsh), 32'(exp_rfsh));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic check_reset_vals(string tag, logic twait, logic [7:0] din, logic [15:0] addr,
                                  logic [7:0] wdata, logic rd, logic we, logic [6:0] rfsh,
                                  logic [15:0] op, logic err);
    check({tag, ".twait"}, 32'(twait), 32'd1);
    check({tag, ".din"}, 32'(din), 32'd0);
    check({tag, ".mem_addr"}, 32'(addr), 32'd0);
    check({tag, ".mem_wdata"}, 32'(wdata), 32'd0);
    check({tag, ".mem_rd"}, 32'(rd), 32'd0);
    check({tag, ".mem_we"}, 32'(we), 32'd0);
    check({tag, ".rfsh_count"}, 32'(rfsh), 32'd0);
    check({tag, ".op_count"}, 32'(op), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  task automatic model_reset();
    exp_din = '0; exp_op = '0; exp_rfsh = '0; exp_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Transaction-level expectation: latency in cycles after the detecting edge.
  task automatic model_op(input kind_e kind, input logic [15:0] addr, input logic [7:0] data,
                          input logic m1, output int la, output int lb);
    la = 0; lb = 0;
    case (kind)
      KRead: begin
        exp_din = ref_mem[addr];
        la = int'(m1 ? WaitM1A : WaitMemA) + 2;
        lb = int'(m1 ? WaitM1B : WaitMemB) + 2;
        if (m1) exp_op = exp_op + 16'd1;
        exp_rd++;
      end
      KWrite: begin
        ref_mem[addr] = data;
        la = int'(WaitMemA) + 1;
        lb = int'(WaitMemB) + 1;
        exp_we++;
      end
      KRfsh: exp_rfsh = exp_rfsh + 7'd1;
      KErr: exp_err = 1'b1;
      default: ;
    endcase
  endtask

  // Drive one CPU bus cycle, wait for both responders to release TWAIT, then drop MREQ.
  task automatic run_op(input kind_e kind, input logic [15:0] addr, input logic [7:0] data,
                        input logic m1, output int lat_a, output int lat_b);
    bit da, db;
    @(negedge clk);
    cpu_ad = addr; cpu_dout = data; cpu_m1 = m1; cpu_mreq = 1'b1;
    cpu_rd = (kind == KRead) || (kind == KErr);
    cpu_wr = (kind == KWrite) || (kind == KErr);
    cpu_rfsh = (kind == KRfsh);
    lat_a = -1; lat_b = -1; da = 0; db = 0;
    for (int k = 0; k < 24 && !(da && db); k++) begin
      @(posedge clk);
      #1;
      if (!da && bus_a.TWAIT) begin lat_a = k; da = 1; end
      if (!db && bus_b.TWAIT) begin lat_b = k; db = 1; end
    end
    if (!da || !db) begin
      n_tests++;
      n_fail++;
      $display("FAIL twait_timeout: got twait a=%0d b=%0d required 1", bus_a.TWAIT, bus_b.TWAIT);
    end
    @(negedge clk);
    cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_rfsh = 1'b0; cpu_m1 = 1'b0;
    @(posedge clk);
  endtask

  task automatic op_and_check(string tag, input kind_e kind, input logic [15:0] addr,
                              input logic [7:0] data, input logic m1);
    int la, lb, ma, mb;
    model_op(kind, addr, data, m1, ma, mb);
    run_op(kind, addr, data, m1, la, lb);
    #1;
    check({tag, ".lat_a"}, 32'(la), 32'(ma));
    check({tag, ".lat_b"}, 32'(lb), 32'(mb));
    check_outs({tag, ".a"}, bus_a.Din, bus_a.OP_Count, bus_a.RFSH_Count, bus_a.ERR);
    check_outs({tag, ".b"}, bus_b.Din, bus_b.OP_Count, bus_b.RFSH_Count, bus_b.ERR);
    check({tag, ".rd_pulses"}, 32'(rd_a + rd_b), 32'(2 * exp_rd));
    check({tag, ".we_pulses"}, 32'(we_a + we_b), 32'(2 * exp_we));
  endtask

  vec_t vecs[8];

  initial begin
    int la, lb, ma, mb, snap_a, snap_b;
    logic [15:0] a16;

    vecs[0] = '{KRead,  16'h0000, 8'h00, 1'b1, 8'h3E, 3, 4, 16'd1, 7'd0};
    vecs[1] = '{KWrite, 16'h8000, 8'hA5, 1'b0, 8'h3E, 1, 4, 16'd1, 7'd0};
    vecs[2] = '{KRead,  16'h8000, 8'h00, 1'b0, 8'hA5, 2, 5, 16'd1, 7'd0};
    vecs[3] = '{KRfsh,  16'h0000, 8'h00, 1'b0, 8'hA5, 0, 0, 16'd1, 7'd1};
    vecs[4] = '{KRead,  16'h1234, 8'h00, 1'b1, 8'h18, 3, 4, 16'd2, 7'd1};
    vecs[5] = '{KNone,  16'h5555, 8'h00, 1'b0, 8'h18, 0, 0, 16'd2, 7'd1};
    vecs[6] = '{KWrite, 16'h1234, 8'h77, 1'b1, 8'h18, 1, 4, 16'd2, 7'd1};
    vecs[7] = '{KRead,  16'h1234, 8'h00, 1'b0, 8'h77, 2, 5, 16'd2, 7'd1};

    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = init_byte(i);
      mem_b[i] = init_byte(i);
      ref_mem[i] = init_byte(i);
    end

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst.a", bus_a.TWAIT, bus_a.Din, bus_a.MEM_Addr, bus_a.MEM_Wdata,
                     bus_a.MEM_Rd, bus_a.MEM_We, bus_a.RFSH_Count, bus_a.OP_Count, bus_a.ERR);
    check_reset_vals("rst.b", bus_b.TWAIT, bus_b.Din, bus_b.MEM_Addr, bus_b.MEM_Wdata,
                     bus_b.MEM_Rd, bus_b.MEM_We, bus_b.RFSH_Count, bus_b.OP_Count, bus_b.ERR);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 8; i++) begin
      model_op(vecs[i].kind, vecs[i].addr, vecs[i].data, vecs[i].m1, ma, mb);
      run_op(vecs[i].kind, vecs[i].addr, vecs[i].data, vecs[i].m1, la, lb);
      #1;
      check($sformatf("vec%0d.lat_a", i), 32'(la), 32'(vecs[i].exp_lat_a));
      check($sformatf("vec%0d.lat_b", i), 32'(lb), 32'(vecs[i].exp_lat_b));
      check($sformatf("vec%0d.din_a", i), 32'(bus_a.Din), 32'(vecs[i].exp_din));
      check($sformatf("vec%0d.din_b", i), 32'(bus_b.Din), 32'(vecs[i].exp_din));
      check($sformatf("vec%0d.op_a", i), 32'(bus_a.OP_Count), 32'(vecs[i].exp_op));
      check($sformatf("vec%0d.rfsh_a", i), 32'(bus_a.RFSH_Count), 32'(vecs[i].exp_rfsh));
      check($sformatf("vec%0d.err_a", i), 32'(bus_a.ERR), 32'd0);
      if (vecs[i].kind == KWrite) begin
        check($sformatf("vec%0d.mem_addr_a", i), 32'(bus_a.MEM_Addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d.mem_wdata_a", i), 32'(bus_a.MEM_Wdata), 32'(vecs[i].data));
      end
    end
    check("vec.we_pulses_a", 32'(we_a), 32'd2);
    check("vec.rd_pulses_a", 32'(rd_a), 32'd4);

    // Illegal RD+WR: sticky error survives a good read, clears only on reset.
    op_and_check("err", KErr, 16'h2222, 8'h00, 1'b0);
    op_and_check("err_then_read", KRead, 16'h0003, 8'h00, 1'b1);
    do_reset();
    #1;
    check("err_after_reset_a", 32'(bus_a.ERR), 32'd0);
    check("err_after_reset_b", 32'(bus_b.ERR), 32'd0);

    // 128 refresh cycles wrap the 7-bit counter back to zero.
    snap_a = rd_a + we_a;
    for (int i = 0; i < 128; i++) begin
      model_op(KRfsh, 16'h0000, 8'h00, 1'b0, ma, mb);
      run_op(KRfsh, 16'h0000, 8'h00, 1'b0, la, lb);
    end
    #1;
    check("rfsh_wrap_a", 32'(bus_a.RFSH_Count), 32'd0);
    check("rfsh_wrap_b", 32'(bus_b.RFSH_Count), 32'd0);
    check("rfsh_no_access_a", 32'(rd_a + we_a), 32'(snap_a));

    // Randomized transactions against the model.
    for (int i = 0; i < 300; i++) begin
      int r;
      kind_e k;
      r = $urandom_range(0, 19);
      if (r < 8) k = KRead;
      else if (r < 14) k = KWrite;
      else if (r < 17) k = KRfsh;
      else if (r < 19) k = KNone;
      else k = KErr;
      a16 = {($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00, 4'h0, 4'($urandom_range(0, 15))};
      op_and_check($sformatf("rnd%0d", i), k, a16, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset during a read's wait phase: outputs return to reset values at once.
    do_reset();
    op_and_check("pre_rst_read", KRead, 16'h4321, 8'h00, 1'b1);
    @(negedge clk);
    cpu_ad = 16'h4321; cpu_m1 = 1'b1; cpu_mreq = 1'b1; cpu_rd = 1'b1;
    @(posedge clk);
    #2;
    check("rwait_twait_low_a", 32'(bus_a.TWAIT), 32'd0);
    snap_a = rd_a;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_rwait.a", bus_a.TWAIT, bus_a.Din, bus_a.MEM_Addr, bus_a.MEM_Wdata,
                     bus_a.MEM_Rd, bus_a.MEM_We, bus_a.RFSH_Count, bus_a.OP_Count, bus_a.ERR);
    @(negedge clk);
    rst = 1'b0;
    cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_m1 = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_rwait_no_rd_a", 32'(rd_a), 32'(snap_a));

    // Reset during a write's wait phase: no array write on either instance.
    @(negedge clk);
    cpu_ad = 16'h4321; cpu_dout = 8'hEE; cpu_mreq = 1'b1; cpu_wr = 1'b1;
    @(posedge clk);
    #2;
    snap_a = we_a; snap_b = we_b;
    rst = 1'b1;
    #1;
    check("rst_wwait_we_a", 32'(bus_a.MEM_We), 32'd0);
    check("rst_wwait_we_b", 32'(bus_b.MEM_We), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_mreq = 1'b0; cpu_wr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_wwait_no_we_a", 32'(we_a), 32'(snap_a));
    check("rst_wwait_no_we_b", 32'(we_b), 32'(snap_b));
    op_and_check("rst_wwait_readback", KRead, 16'h4321, 8'h00, 1'b0);

    // MREQ dropped one cycle into a write: abort, no write, TWAIT released.
    @(negedge clk);
    cpu_ad = 16'h4444; cpu_dout = 8'h99; cpu_mreq = 1'b1; cpu_wr = 1'b1;
    snap_a = we_a; snap_b = we_b;
    @(posedge clk);
    @(negedge clk);
    cpu_mreq = 1'b0; cpu_wr = 1'b0;
    @(posedge clk);
    #1;
    check("abort_twait_b", 32'(bus_b.TWAIT), 32'd1);
    check("abort_twait_a", 32'(bus_a.TWAIT), 32'd1);
    check("abort_no_we_b", 32'(we_b), 32'(snap_b));
    check("abort_no_we_a", 32'(we_a), 32'(snap_a));
    op_and_check("abort_readback", KRead, 16'h4444, 8'h00, 1'b1);

    check("rd_we_exclusive", 32'(excl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
